lsu_mem_port: RTL and testbench
===============================

# lsu_mem_port

Load/store unit that drives the word-addressed data memory (`DM`) on behalf of the RV32I core. It accepts one byte/halfword/word load or store request at a time and translates it into DM word accesses. Sub-word stores are done as read-modify-write. Loaded data is extracted and sign- or zero-extended. The block sits between the execute stage and `DM`, owning the DM `we`/`addres`/`wd` inputs and consuming `rd`.

## Interface
- `ADDR_W`, 16: DM word-address width (`addres` width).
- `clk` in 1: single clock, all state updates on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present; accepted when `req_valid && req_ready`.
- `req_ready` out 1: high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I size/sign code.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, using the low byte/half/word.
- `rsp_done` out 1: one-cycle pulse when the request completes.
- `rsp_err` out 1: valid with `rsp_done`; misaligned or illegal funct3.
- `rsp_rdata` out 32: load result, held until the next load completes.
- `mem_we` out 1: to DM `we`.
- `mem_addres` out ADDR_W: to DM `addres` (word index).
- `mem_wd` out 32: to DM `wd`.
- `mem_rd` in 32: from DM `rd`, treated as a combinational read of `mem_addres`.

## Operation
- Requests are accepted only in IDLE. At accept, `req_we`, `funct3`, `addr` and `wdata` are latched; input changes afterwards have no effect.
- Word index is `addr[ADDR_W+1:2]`; `addr[31:ADDR_W+2]` is ignored. Byte lane is `addr[1:0]`.
- Legal loads: LB 000, LH 001, LW 010, LBU 100, LHU 101.
- Legal stores: SB 000, SH 001, SW 010.
- Anything else is illegal and produces `rsp_err`.
- Misaligned accesses produce `rsp_err`: halfword with `addr[0]=1`, or word with `addr[1:0]!=0`.
- An erroring request performs no DM access; `mem_we` never rises and `rsp_rdata` is unchanged.
- States and transitions:
  - IDLE → ERR on an accepted erroring request.
  - IDLE → WRITE on an accepted SW.
  - IDLE → READ on any other accepted legal request.
  - READ: drives `mem_addres` and captures `mem_rd` into a word buffer at the clock edge. Goes to DONE for loads, WRITE for SB/SH.
  - WRITE: `mem_we=1` and `mem_wd` = merged word. The merge replaces the addressed byte/half lanes of the buffer with `wdata`; for SW it is `wdata`. Goes to DONE.
  - DONE / ERR: `rsp_done=1` (ERR also sets `rsp_err=1`). Loads update `rsp_rdata` on entry to DONE. Both go to IDLE.
- Load extraction: the lane is selected by `addr[1:0]`. LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.

## Timing
- Cycle 0 is the accept edge.
- Load latency: READ in cycle 1, `rsp_done` in cycle 2.
- SW latency: WRITE in cycle 1 (DM written at the end of cycle 1), `rsp_done` in cycle 2.
- SB/SH latency: READ in cycle 1, WRITE in cycle 2, `rsp_done` in cycle 3.
- Error latency: `rsp_done` with `rsp_err` in cycle 1.
- `req_ready` is low from cycle 1 until the cycle after `rsp_done`. Minimum request spacing is therefore 3 cycles (load/SW), 4 (SB/SH) or 2 (error).
- `mem_we` is high for exactly one cycle per store and never in any other state.
- `mem_addres` holds the latched word index from READ through DONE, and the last value while idle.
- Reset values: IDLE, `req_ready=1`, `rsp_done=0`, `rsp_err=0`, `rsp_rdata=0`, `mem_we=0`, `mem_addres=0`, `mem_wd=0`, buffer 0.
- `req_valid` is ignored while `rst_n=0`.
- Reset mid-operation forces IDLE and `mem_we=0` immediately, asynchronously. A pending RMW write is abandoned and DM keeps its old word. No `rsp_done` is issued for the aborted request.

## Structure
- Shared package/header `lsu_defs`:
  - funct3 constants (LB…SW).
  - State encoding: IDLE, READ, WRITE, DONE, ERR.
  - Size codes.
- Sub-module `lsu_align`: purely combinational. Inputs are the word, lane, `funct3` and `wdata`. Outputs are the extended load value, the merged store word, and the misalign/illegal flags.
- The FSM and registers live in `lsu_mem_port`.

## Test plan
- SW `addr=0x28`, `wdata=0x11223344`, then LW `0x28`: DM[10]=0x11223344 with `mem_we` high in cycle 1 only; LW gives `rsp_rdata=0x11223344` in cycle 2.
- With DM[10]=0x11223344: SB `addr=0x29`, `wdata=0xAB` gives DM[10]=0x1122AB44 in 3 cycles. Then LB `0x29` gives 0xFFFFFFAB; LBU gives 0x000000AB.
- SH `addr=0x2E`, `wdata=0x8001` over DM[11]=0: DM[11]=0x80010000. LH `0x2E` gives 0xFFFF8001; LHU gives 0x00008001.
- Misaligned LW `0x2A`, SH `0x2D`, and illegal funct3 011: each gives `rsp_done` and `rsp_err` in cycle 1, no `mem_we`, and `rsp_rdata` unchanged.
- Back-to-back: `req_valid` held high with changing inputs. Only the accepted values take effect, and accepts are spaced per the latencies above.
- SB in flight: assert `rst_n=0` during WRITE. `mem_we` drops immediately, DM[10] is unchanged, and all outputs return to reset values.

Source files
------------

// File: rtl/lsu_defs.sv
// Shared constants for the load/store unit: funct3 codes, FSM state encoding and access sizes.
package lsu_defs;

  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;
  localparam logic [2:0] F3Sb  = 3'b000;
  localparam logic [2:0] F3Sh  = 3'b001;
  localparam logic [2:0] F3Sw  = 3'b010;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StRead  = 3'd1;
  localparam logic [2:0] StWrite = 3'd2;
  localparam logic [2:0] StDone  = 3'd3;
  localparam logic [2:0] StErr   = 3'd4;

  localparam logic [1:0] SzByte = 2'd0;
  localparam logic [1:0] SzHalf = 2'd1;
  localparam logic [1:0] SzWord = 2'd2;
  localparam logic [1:0] SzBad  = 2'd3;

  // funct3[1:0] carries the access size for both loads and stores.
  function automatic logic [1:0] size_of(input logic [2:0] funct3);
    return funct3[1:0];
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extraction/extension, store merge and legality checks.
module lsu_align
  import lsu_defs::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  input  logic        is_store,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] store_word,
  output logic        misalign,
  output logic        illegal
);

  logic [1:0]  sz;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        sext;

  always_comb begin
    sz       = size_of(funct3);
    sext     = ~funct3[2];
    illegal  = (sz == SzBad) || (is_store && funct3[2]);
    misalign = ((sz == SzHalf) && lane[0]) || ((sz == SzWord) && (lane != 2'b00));

    unique case (lane)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      default: byte_v = word[31:24];
    endcase
    half_v = lane[1] ? word[31:16] : word[15:0];

    load_val = '0;
    case (sz)
      SzByte:  load_val = {{24{sext & byte_v[7]}}, byte_v};
      SzHalf:  load_val = {{16{sext & half_v[15]}}, half_v};
      SzWord:  load_val = word;
      default: load_val = '0;
    endcase

    // Sub-word stores overwrite only the addressed lanes of the buffered word.
    store_word = word;
    case (sz)
      SzByte: begin
        unique case (lane)
          2'd0:    store_word[7:0]   = wdata[7:0];
          2'd1:    store_word[15:8]  = wdata[7:0];
          2'd2:    store_word[23:16] = wdata[7:0];
          default: store_word[31:24] = wdata[7:0];
        endcase
      end
      SzHalf: begin
        if (lane[1]) store_word[31:16] = wdata[15:0];
        else         store_word[15:0]  = wdata[15:0];
      end
      SzWord:  store_word = wdata;
      default: store_word = word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit front-end for the word-addressed data memory; sub-word stores use
// read-modify-write through an internal word buffer.
module lsu_mem_port
  import lsu_defs::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_done,
  output logic              rsp_err,
  output logic [31:0]       rsp_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addres,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
);

  logic [2:0]        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        lane_q, lane_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] widx_q, widx_d;
  logic [31:0]       buf_q, buf_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              idle;
  logic [31:0]       a_word;
  logic [1:0]        a_lane;
  logic [2:0]        a_f3;
  logic              a_store;
  logic [31:0]       load_val;
  logic [31:0]       store_word;
  logic              misalign;
  logic              illegal;

  // Address bits above the DM word index are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  assign idle = (state_q == StIdle);

  // While idle the aligner checks the incoming request; otherwise it works on latched fields.
  always_comb begin
    a_lane  = idle ? req_addr[1:0] : lane_q;
    a_f3    = idle ? req_funct3    : f3_q;
    a_store = idle ? req_we        : we_q;
    a_word  = (state_q == StRead) ? mem_rd : buf_q;
  end

  lsu_align u_align (
    .word       (a_word),
    .lane       (a_lane),
    .funct3     (a_f3),
    .is_store   (a_store),
    .wdata      (wdata_q),
    .load_val   (load_val),
    .store_word (store_word),
    .misalign   (misalign),
    .illegal    (illegal)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    lane_d  = lane_q;
    wdata_d = wdata_q;
    widx_d  = widx_q;
    buf_d   = buf_q;
    rdata_d = rdata_q;

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          lane_d  = req_addr[1:0];
          wdata_d = req_wdata;
          if (misalign || illegal) begin
            state_d = StErr;
          end else begin
            widx_d  = req_addr[ADDR_W+1:2];
            state_d = (req_we && (req_funct3 == F3Sw)) ? StWrite : StRead;
          end
        end
      end
      StRead: begin
        buf_d = mem_rd;
        if (we_q) begin
          state_d = StWrite;
        end else begin
          rdata_d = load_val;
          state_d = StDone;
        end
      end
      StWrite: state_d = StDone;
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      lane_q  <= 2'b00;
      wdata_q <= '0;
      widx_q  <= '0;
      buf_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      lane_q  <= lane_d;
      wdata_q <= wdata_d;
      widx_q  <= widx_d;
      buf_q   <= buf_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    req_ready  = idle;
    rsp_done   = (state_q == StDone) || (state_q == StErr);
    rsp_err    = (state_q == StErr);
    rsp_rdata  = rdata_q;
    mem_we     = (state_q == StWrite);
    mem_addres = widx_q;
    mem_wd     = (state_q == StWrite) ? store_word : '0;
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed scoreboard bench for lsu_mem_port with a behavioural word memory.
`timescale 1ns/1ps
module tb_lsu_mem_port;
  import lsu_defs::*;

  localparam int unsigned ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [2:0]        req_funct3 = 3'b000;
  logic [31:0]       req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              rsp_done;
  logic              rsp_err;
  logic [31:0]       rsp_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addres;
  logic [31:0]       mem_wd;
  logic [31:0]       mem_rd;

  logic [31:0] dm [0:255];

  lsu_mem_port #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_done   (rsp_done),
    .rsp_err    (rsp_err),
    .rsp_rdata  (rsp_rdata),
    .mem_we     (mem_we),
    .mem_addres (mem_addres),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) dm[mem_addres[7:0]] <= mem_wd;
  assign mem_rd = dm[mem_addres[7:0]];

  typedef struct {
    logic        err;
    logic [31:0] rd;
    int          lat;
    int          we_at;
    time         t_acc;
  } exp_t;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        err;
    logic [31:0] rd;
    int          lat;
    int          we_at;
  } step_t;

  exp_t  sb[$];
  int    checks = 0;
  int    errors = 0;
  int    we_cnt = 0;
  int    we_at_obs = 0;
  logic  ignore_we = 1'b0;
  logic [31:0] cur;
  step_t tbl [15];

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Negedge index after the accept edge at which the current cycle falls.
  function automatic int lat_of(input time t_acc);
    return int'(($time - t_acc - 5) / 10) + 1;
  endfunction

  function automatic step_t mk(input logic we, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd, input logic err, input logic [31:0] rd,
                               input int lat, input int we_at);
    return '{we, f3, a, wd, err, rd, lat, we_at};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (mem_we && !ignore_we) begin
        we_cnt++;
        check32("we_has_request", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) we_at_obs = lat_of(sb[0].t_acc);
      end
      if (rsp_done) begin
        check32("done_has_request", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check32("rsp_err", 32'(rsp_err), 32'(e.err));
          check32("rsp_rdata", rsp_rdata, e.rd);
          check32("latency", lat_of(e.t_acc), e.lat);
          check32("we_cycles", we_cnt, 32'(e.we_at != 0));
          check32("we_cycle_index", we_at_obs, e.we_at);
        end
        we_cnt    = 0;
        we_at_obs = 0;
      end
    end
  end

  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    req_valid  = 1'b1;
  endtask

  task automatic wait_empty(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check32(tag, sb.size(), 0);
    sb.delete();
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic err, input logic [31:0] rd,
                        input int lat, input int we_at);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check32("ready_before_req", 32'(req_ready), 32'd1);
    drive(we, f3, a, wd);
    @(posedge clk);
    sb.push_back('{err, rd, lat, we_at, $time});
    @(negedge clk);
    req_valid = 1'b0;
    wait_empty("response_seen");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int next_acc;
    for (int i = 0; i < 256; i++) dm[i] = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check32("rst_req_ready", 32'(req_ready), 32'd1);
    check32("rst_rsp_done", 32'(rsp_done), 32'd0);
    check32("rst_rsp_err", 32'(rsp_err), 32'd0);
    check32("rst_rsp_rdata", rsp_rdata, 32'd0);
    check32("rst_mem_we", 32'(mem_we), 32'd0);
    check32("rst_mem_addres", 32'(mem_addres), 32'd0);
    check32("rst_mem_wd", mem_wd, 32'd0);
    rst_n = 1'b1;

    cur = 32'h0;
    do_req(1'b1, F3Sw, 32'h28, 32'h11223344, 1'b0, cur, 2, 1);
    check32("dm10_after_sw", dm[10], 32'h11223344);
    cur = 32'h11223344;
    do_req(1'b0, F3Lw, 32'h28, 32'h0, 1'b0, cur, 2, 0);
    do_req(1'b1, F3Sb, 32'h29, 32'hAB, 1'b0, cur, 3, 2);
    check32("dm10_after_sb", dm[10], 32'h1122AB44);
    cur = 32'hFFFFFFAB;
    do_req(1'b0, F3Lb, 32'h29, 32'h0, 1'b0, cur, 2, 0);
    cur = 32'h000000AB;
    do_req(1'b0, F3Lbu, 32'h29, 32'h0, 1'b0, cur, 2, 0);
    do_req(1'b1, F3Sh, 32'h2E, 32'h8001, 1'b0, cur, 3, 2);
    check32("dm11_after_sh", dm[11], 32'h80010000);
    cur = 32'hFFFF8001;
    do_req(1'b0, F3Lh, 32'h2E, 32'h0, 1'b0, cur, 2, 0);
    cur = 32'h00008001;
    do_req(1'b0, F3Lhu, 32'h2E, 32'h0, 1'b0, cur, 2, 0);

    do_req(1'b0, F3Lw, 32'h2A, 32'h0, 1'b1, cur, 1, 0);
    do_req(1'b1, F3Sh, 32'h2D, 32'hFFFF, 1'b1, cur, 1, 0);
    do_req(1'b0, 3'b011, 32'h28, 32'h0, 1'b1, cur, 1, 0);
    check32("dm11_after_err", dm[11], 32'h80010000);

    // Back-to-back: only entries presented while idle are accepted.
    tbl[0]  = mk(1'b0, F3Lw,   32'h28, 32'h0,        1'b0, 32'h1122AB44, 2, 0);
    tbl[1]  = mk(1'b1, F3Sw,   32'h2C, 32'hDEADBEEF, 1'b0, 32'h0,        0, 0);
    tbl[2]  = mk(1'b1, F3Sb,   32'h28, 32'h0,        1'b0, 32'h0,        0, 0);
    tbl[3]  = mk(1'b1, F3Sb,   32'h2A, 32'h77,       1'b0, 32'h1122AB44, 3, 2);
    tbl[4]  = mk(1'b0, F3Lw,   32'h00, 32'h0,        1'b0, 32'h0,        0, 0);
    tbl[5]  = mk(1'b1, F3Sw,   32'h28, 32'h0,        1'b0, 32'h0,        0, 0);
    tbl[6]  = mk(1'b1, F3Sh,   32'h2E, 32'h0,        1'b0, 32'h0,        0, 0);
    tbl[7]  = mk(1'b0, F3Lbu,  32'h2A, 32'h0,        1'b0, 32'h00000077, 2, 0);
    tbl[8]  = mk(1'b1, F3Sw,   32'h2C, 32'hFFFFFFFF, 1'b0, 32'h0,        0, 0);
    tbl[9]  = mk(1'b1, F3Sb,   32'h2F, 32'h12,       1'b0, 32'h0,        0, 0);
    tbl[10] = mk(1'b0, 3'b111, 32'h28, 32'h0,        1'b1, 32'h00000077, 1, 0);
    tbl[11] = mk(1'b1, F3Sw,   32'h2C, 32'h1,        1'b0, 32'h0,        0, 0);
    tbl[12] = mk(1'b0, F3Lh,   32'h2E, 32'h0,        1'b0, 32'hFFFF8001, 2, 0);
    tbl[13] = mk(1'b1, F3Sw,   32'h28, 32'hCAFE0000, 1'b0, 32'h0,        0, 0);
    tbl[14] = mk(1'b1, F3Sb,   32'h2C, 32'h5,        1'b0, 32'h0,        0, 0);
    next_acc = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      check32("b2b_ready", 32'(req_ready), 32'(k == next_acc));
      drive(tbl[k].we, tbl[k].f3, tbl[k].addr, tbl[k].wd);
      if (k == next_acc) begin
        sb.push_back('{tbl[k].err, tbl[k].rd, tbl[k].lat, tbl[k].we_at, $time + 5});
        next_acc = k + tbl[k].lat + 1;
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    wait_empty("b2b_drained");
    check32("dm10_after_b2b", dm[10], 32'h1177AB44);
    check32("dm11_after_b2b", dm[11], 32'h80010000);

    // Reset during the write phase of a read-modify-write byte store.
    ignore_we = 1'b1;
    @(negedge clk);
    check32("abort_ready", 32'(req_ready), 32'd1);
    drive(1'b1, F3Sb, 32'h28, 32'h55);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check32("abort_we_in_write", 32'(mem_we), 32'd1);
    #1 rst_n = 1'b0;
    drive(1'b0, F3Lw, 32'h28, 32'h0);
    #1;
    check32("abort_mem_we", 32'(mem_we), 32'd0);
    check32("abort_req_ready", 32'(req_ready), 32'd1);
    check32("abort_rsp_done", 32'(rsp_done), 32'd0);
    check32("abort_rsp_err", 32'(rsp_err), 32'd0);
    check32("abort_rsp_rdata", rsp_rdata, 32'd0);
    check32("abort_mem_addres", 32'(mem_addres), 32'd0);
    check32("abort_mem_wd", mem_wd, 32'd0);
    repeat (2) begin
      @(negedge clk);
      check32("in_reset_done", 32'(rsp_done), 32'd0);
      check32("in_reset_we", 32'(mem_we), 32'd0);
    end
    req_valid = 1'b0;
    rst_n     = 1'b1;
    ignore_we = 1'b0;
    we_cnt    = 0;
    we_at_obs = 0;
    check32("dm10_after_abort", dm[10], 32'h1177AB44);
    cur = 32'h1177AB44;
    do_req(1'b0, F3Lw, 32'h28, 32'h0, 1'b0, cur, 2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
